// File: rtl/sound_ram_player.sv
// Playback reader: walks sound_ram over a latched [lo,hi] range and streams samples out.
// Latency: start -> sample_valid after 2 edges; 3 cycles/sample at best; holds sample while !sample_ready.
module sound_ram_player #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 65
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt, lo, lo_nxt, hi, hi_nxt, ram_addr_nxt, end_eff;
  logic [DATA_W-1:0]   sample_nxt;
  logic                valid_nxt, done_nxt, err_nxt;

  assign ram_we  = 1'b0;
  assign busy    = (state != IDLE);
  assign end_eff = (end_addr > LAST) ? LAST : end_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lo_nxt       = lo;
    hi_nxt       = hi;
    ram_addr_nxt = ram_addr;
    sample_nxt   = sample_out;
    valid_nxt    = sample_valid;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        // stop in the same cycle suppresses the start entirely
        if (start && !stop) begin
          if (start_addr > end_eff) begin
            err_nxt = 1'b1;
          end else begin
            lo_nxt       = start_addr;
            hi_nxt       = end_eff;
            ptr_nxt      = start_addr;
            ram_addr_nxt = start_addr;
            state_nxt    = ADDR;
          end
        end
      end
      ADDR: state_nxt = stop ? IDLE : DATA;
      DATA: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          sample_nxt = ram_rdata;
          valid_nxt  = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (sample_ready) begin
          valid_nxt = 1'b0;
          if (stop) begin
            state_nxt = IDLE;
          end else if (ptr != hi) begin
            ptr_nxt      = ptr + 1'b1;
            ram_addr_nxt = ptr + 1'b1;
            state_nxt    = ADDR;
          end else if (loop_en) begin
            ptr_nxt      = lo;
            ram_addr_nxt = lo;
            state_nxt    = ADDR;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else if (stop) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      lo           <= '0;
      hi           <= '0;
      ram_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ptr          <= ptr_nxt;
      lo           <= lo_nxt;
      hi           <= hi_nxt;
      ram_addr     <= ram_addr_nxt;
      sample_out   <= sample_nxt;
      sample_valid <= valid_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sound_ram_player.sv
// Bench for sound_ram_player: random RAM image, registered-read RAM model, and an
// arithmetic reference for the expected sample order over the clipped range.
module tb_sound_ram_player;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 65;

  logic              clk = 1'b0;
  logic              reset_n, start, stop, loop_en, sample_ready;
  logic [ADDR_W-1:0] start_addr, end_addr, ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata, sample_out;
  logic              sample_valid, busy, done, err;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] got[$];
  int                gotcyc[$];
  int                ndone, nerr, cyc;
  int                checks = 0;
  int                failures = 0;

  sound_ram_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : '0;
  end

  // Transfer/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (sample_valid && sample_ready) begin
        got.push_back(sample_out);
        gotcyc.push_back(cyc);
      end
      if (done) ndone++;
      if (err)  nerr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got.delete();
    gotcyc.delete();
    ndone = 0;
    nerr  = 0;
  endtask

  task automatic do_start(input int s, input int e, input bit l);
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    loop_en    = l;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound, input bit rnd);
    int k = 0;
    while (ndone == 0 && k < bound) begin
      if (rnd) sample_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    sample_ready = 1'b1;
    check(tag, 32'(ndone != 0), 32'd1);
    tick();
    tick();
  endtask

  // Expected i-th transfer: ranges repeat from lo when looping.
  task automatic compare_seq(input string tag, input int s, input int e, input int count);
    int hi, n;
    hi = (e > DEPTH - 1) ? DEPTH - 1 : e;
    n  = hi - s + 1;
    check({tag, "_count"}, 32'(got.size()), 32'(count));
    for (int i = 0; i < count && i < got.size(); i++)
      check(tag, 32'(got[i]), 32'(mem[s + (i % n)]));
  endtask

  initial begin
    int v_lo, v_e, k;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; sample_ready = 1'b1;
    start_addr = '0; end_addr = '0; ndone = 0; nerr = 0; cyc = 0;
    #3;
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_out",   32'(sample_out), 32'd0);
    check("rst_addr",  32'(ram_addr), 32'd0);
    check("rst_pulses", {30'd0, done, err}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    check("ram_we", 32'(ram_we), 32'd0);

    // 1: straight play 3..5 with latency and pacing
    clear_log();
    do_start(3, 5, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_addr", 32'(ram_addr), 32'd3);
    check("t1_valid_n0", 32'(sample_valid), 32'd0);
    tick();
    check("t1_valid_n1", 32'(sample_valid), 32'd0);
    tick();
    check("t1_valid_n2", 32'(sample_valid), 32'd1);
    check("t1_first", 32'(sample_out), 32'(mem[3]));
    wait_done("t1_done_timeout", 40, 1'b0);
    compare_seq("t1_seq", 3, 5, 3);
    for (int i = 1; i < gotcyc.size(); i++)
      check("t1_gap", 32'(gotcyc[i] - gotcyc[i-1]), 32'd3);
    check("t1_ndone", 32'(ndone), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: looping, stop after seven transfers
    clear_log();
    do_start(3, 5, 1'b1);
    k = 0;
    while (got.size() < 7 && k < 60) begin tick(); k++; end
    check("t2_timeout", 32'(got.size() >= 7), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    compare_seq("t2_seq", 3, 5, 7);
    check("t2_ndone", 32'(ndone), 32'd0);

    // 3: backpressure holds the sample
    clear_log();
    sample_ready = 1'b0;
    do_start(3, 5, 1'b0);
    k = 0;
    while (!sample_valid && k < 10) begin tick(); k++; end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 32'(sample_valid), 32'd1);
      check("t3_hold_data", 32'(sample_out), 32'(mem[3]));
    end
    check("t3_no_xfer", 32'(got.size()), 32'd0);
    sample_ready = 1'b1;
    wait_done("t3_done_timeout", 40, 1'b0);
    compare_seq("t3_seq", 3, 5, 3);

    // 4: rejected range, then clipping at DEPTH-1
    clear_log();
    do_start(10, 4, 1'b0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    tick();
    check("t4_err_pulse", 32'(err), 32'd0);
    check("t4_nerr", 32'(nerr), 32'd1);
    clear_log();
    do_start(62, 200, 1'b0);
    check("t4_noerr", 32'(err), 32'd0);
    wait_done("t4_done_timeout", 40, 1'b0);
    compare_seq("t4_clip", 62, 200, 3);

    // 5: stop during DATA, then restart
    clear_log();
    do_start(3, 5, 1'b0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(sample_valid), 32'd0);
    repeat (3) tick();
    check("t5_no_xfer", 32'(got.size()), 32'd0);
    check("t5_ndone", 32'(ndone), 32'd0);
    do_start(3, 5, 1'b0);
    wait_done("t5_done_timeout", 40, 1'b0);
    compare_seq("t5_seq", 3, 5, 3);

    // random ranges with random ready
    for (int r = 0; r < 4; r++) begin
      clear_log();
      v_lo = $urandom_range(0, DEPTH - 3);
      v_e  = v_lo + $urandom_range(0, 8);
      do_start(v_lo, v_e, 1'b0);
      wait_done("rnd_done_timeout", 300, 1'b1);
      compare_seq("rnd_seq", v_lo, v_e, ((v_e > DEPTH - 1) ? DEPTH - 1 : v_e) - v_lo + 1);
      check("rnd_ndone", 32'(ndone), 32'd1);
    end

    // 6: async reset while holding a sample
    clear_log();
    sample_ready = 1'b0;
    do_start(20, 30, 1'b0);
    k = 0;
    while (!sample_valid && k < 10) begin tick(); k++; end
    check("t6_in_out", 32'(sample_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(sample_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_out", 32'(sample_out), 32'd0);
    check("t6_addr", 32'(ram_addr), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    sample_ready = 1'b1;
    repeat (3) tick();
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_no_xfer", 32'(got.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
